// File: rtl/voice_mixer_pkg.sv
// voice_mixer_pkg: shared widths, FSM states and helpers
// for the voice mixer slice.
package voice_mixer_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int SUM_W          = 18;
  localparam int NUM_VOICES_MAX = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_SUM,
    S_OUT
  } state_t;

  function automatic logic signed [SUM_W-1:0] sext(
    input logic [SAMPLE_W-1:0] s
  );
    return {{(SUM_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

endpackage

// File: rtl/mix_voice_slot.sv
// mix_voice_slot: per-voice hold register, pending bit
// and overrun detection.
module mix_voice_slot
  import voice_mixer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_ready,
  input  logic                i_clr,
  output logic [SAMPLE_W-1:0] o_hold,
  output logic                o_pending,
  output logic                o_overrun
);

  logic [SAMPLE_W-1:0] r_hold;
  logic                r_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (i_ready) begin
        r_hold <= i_sample;
      end
      // a fresh pulse outranks the end-of-frame clear
      if (i_ready) begin
        r_pending <= 1'b1;
      end else if (i_clr) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_hold    = r_hold;
  assign o_pending = r_pending;
  assign o_overrun = i_ready & r_pending & ~i_clr;

endmodule

// File: rtl/voice_mixer.sv
// voice_mixer: collects one sample per enabled voice, sums, shifts.
// Optional output saturation: define VOICE_MIXER_SAT_EN.
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int TIMEOUT    = 64,
  parameter int NUM_VOICES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in_0,
  input  logic [15:0] sample_in_1,
  input  logic [15:0] sample_in_2,
  input  logic [2:0]  ready_in,
  input  logic [2:0]  voice_en,
  input  logic [1:0]  gain_shift,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        overrun,
  output logic        clip,
  input  logic        clear_flags
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t r_state;
  state_t w_next;

  logic [SAMPLE_W-1:0]       w_in   [NUM_VOICES_MAX];
  logic [SAMPLE_W-1:0]       w_hold [NUM_VOICES_MAX];
  logic [NUM_VOICES_MAX-1:0] w_pend;
  logic [NUM_VOICES_MAX-1:0] w_ovr;

  logic                    w_clr;
  logic                    w_start;
  logic                    w_done;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_expired;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_shift;
  logic [SAMPLE_W-1:0]     w_mix;
  logic                    w_lim;
  logic [SAMPLE_W-1:0]     r_out;
  logic                    r_valid;
  logic                    r_ovr;

  assign w_in[0] = sample_in_0;
  assign w_in[1] = sample_in_1;
  assign w_in[2] = sample_in_2;

  assign w_clr = (r_state == S_SUM);

  for (genvar k = 0; k < NUM_VOICES; k++) begin : g_slot
    mix_voice_slot u_slot (
      .clk       (clk),
      .reset     (reset),
      .i_sample  (w_in[k]),
      .i_ready   (ready_in[k]),
      .i_clr     (w_clr),
      .o_hold    (w_hold[k]),
      .o_pending (w_pend[k]),
      .o_overrun (w_ovr[k])
    );
  end

  // with every voice disabled any pulse still opens a (silent) frame
  assign w_start = (|(ready_in & voice_en))
                 | ((~|voice_en) & (|ready_in));
  assign w_done  = ((w_pend & voice_en) == voice_en);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_done || r_expired) begin
          w_next = S_SUM;
        end
      end
      S_SUM: begin
        w_next = S_OUT;
      end
      S_OUT: begin
        w_next = (|w_pend) ? S_COLLECT : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // expiry is registered so it behaves like a final capture edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else if (r_state != S_COLLECT) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else begin
      r_cnt     <= r_cnt + 1'b1;
      r_expired <= (r_cnt == CNT_LAST);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NUM_VOICES_MAX; k++) begin
      if (voice_en[k]) begin
        w_sum = w_sum + sext(w_hold[k]);
      end
    end
  end

  assign w_shift = w_sum >>> gain_shift;

`ifdef VOICE_MIXER_SAT_EN
  localparam logic signed [SUM_W-1:0] MAX_V =
    SUM_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] MIN_V = -MAX_V - 1;

  logic r_clip;

  always_comb begin
    w_mix = w_shift[SAMPLE_W-1:0];
    w_lim = 1'b0;
    if (w_shift > MAX_V) begin
      w_mix = MAX_V[SAMPLE_W-1:0];
      w_lim = 1'b1;
    end else if (w_shift < MIN_V) begin
      w_mix = MIN_V[SAMPLE_W-1:0];
      w_lim = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clip <= 1'b0;
    end else begin
      r_clip <= (w_clr & w_lim) | (r_clip & ~clear_flags);
    end
  end

  assign clip = r_clip;
`else
  logic w_unused_msb;

  assign w_mix        = w_shift[SAMPLE_W-1:0];
  assign w_lim        = 1'b0;
  assign w_unused_msb = ^{w_shift[SUM_W-1:SAMPLE_W], w_lim};
  assign clip         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_valid <= w_clr;
      if (w_clr) begin
        r_out <= w_mix;
      end
      r_ovr <= (|w_ovr) | (r_ovr & ~clear_flags);
    end
  end

  assign sample_out   = r_out;
  assign sample_valid = r_valid;
  assign overrun      = r_ovr;

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed and random frames against an
// arithmetic reference model of the mixer.
module tb_voice_mixer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sample_in_0 = '0;
  logic [15:0] sample_in_1 = '0;
  logic [15:0] sample_in_2 = '0;
  logic [2:0]  ready_in = '0;
  logic [2:0]  voice_en = '0;
  logic [1:0]  gain_shift = '0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        overrun;
  logic        clip;
  logic        clear_flags = 1'b0;

  int total = 0;
  int bad = 0;
  int mhold [3] = '{0, 0, 0};
  bit mclip = 1'b0;

  always #5 clk = ~clk;

  voice_mixer #(
    .TIMEOUT    (TO),
    .NUM_VOICES (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in_0  (sample_in_0),
    .sample_in_1  (sample_in_1),
    .sample_in_2  (sample_in_2),
    .ready_in     (ready_in),
    .voice_en     (voice_en),
    .gain_shift   (gain_shift),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .clip         (clip),
    .clear_flags  (clear_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [2:0] m, input int a, input int b,
                       input int c);
    if (m[0]) begin sample_in_0 = 16'(a); mhold[0] = a; end
    if (m[1]) begin sample_in_1 = 16'(b); mhold[1] = b; end
    if (m[2]) begin sample_in_2 = 16'(c); mhold[2] = c; end
    ready_in = m;
    tick();
    ready_in = '0;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (sample_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // sum of enabled held samples, floor-divided by 2^sh, then clamped or wrapped
  function automatic int mix_model(input logic [2:0] en, input int sh,
                                   output bit lim);
    int s;
    int w;
    s = 0;
    lim = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (en[k]) s += mhold[k];
    end
    s = s >>> sh;
`ifdef VOICE_MIXER_SAT_EN
    if (s > 32767) begin lim = 1'b1; return 32767; end
    if (s < -32768) begin lim = 1'b1; return -32768; end
    w = s;
`else
    w = s & 32'hFFFF;
    if (w > 32767) w -= 65536;
`endif
    return w;
  endfunction

  task automatic run_frame(input string tag,
                           input int v0, input int v1, input int v2,
                           input int o0, input int o1, input int o2,
                           input logic [2:0] en, input int sh);
    int off [3];
    int mx, first, last, n, exp_lat, exp_val;
    bit lim, allp, early;
    logic [2:0] m;
    off = '{o0, o1, o2};
    voice_en = en;
    gain_shift = 2'(sh);
    mx = -1; first = 1000; last = -1; allp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (off[k] > mx) mx = off[k];
      if (off[k] >= 0 && (en[k] || en == 3'b000)) begin
        if (off[k] < first) first = off[k];
        if (en[k] && off[k] > last) last = off[k];
      end
      if (en[k] && off[k] < 0) allp = 1'b0;
    end
    if (en == 3'b000) last = first;
    early = 1'b0;
    for (int c = 0; c <= mx; c++) begin
      m = '0;
      for (int k = 0; k < 3; k++) if (off[k] == c) m[k] = 1'b1;
      pulse(m, v0, v1, v2);
      if (sample_valid !== 1'b0) early = 1'b1;
    end
    exp_val = mix_model(en, sh, lim);
    if (lim) mclip = 1'b1;
    exp_lat = allp ? (last - first + 2) : (TO + 2);
    wait_valid(n);
    chk({tag, ".early"}, int'(early), 0);
    chk({tag, ".lat"}, (n < 0) ? -1 : (mx - first + n), exp_lat);
    chk({tag, ".out"}, int'($signed(sample_out)), exp_val);
    chk({tag, ".clip"}, int'(clip), int'(mclip));
    tick();
    chk({tag, ".once"}, int'(sample_valid), 0);
  endtask

  initial begin
    int n;
    int rv [3];
    int ro [3];
    int rmax;
    int rsh;
    logic [2:0] ren;
    bit seen;

    tick();
    tick();
    chk("rst.out", int'(sample_out), 0);
    chk("rst.valid", int'(sample_valid), 0);
    chk("rst.ovr", int'(overrun), 0);
    chk("rst.clip", int'(clip), 0);
    reset = 1'b1;
    tick();

    run_frame("s033", 1000, 2000, 3000, 0, 2, 5, 3'b111, 0);
    repeat (3) tick();
    chk("s033.hold", int'($signed(sample_out)), 6000);

    run_frame("s034", 20000, 20000, 20000, 0, 1, 2, 3'b111, 0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    mclip = 1'b0;
    chk("s034.clr", int'(clip), 0);

    run_frame("seed", 0, 0, 50, 0, 1, 2, 3'b111, 0);
    run_frame("s035", 100, 200, 0, 0, 1, -1, 3'b111, 0);

    run_frame("s036", -4000, 7, 1000, 0, 1, 3, 3'b101, 1);
    run_frame("s024", 0, 1234, 0, -1, 0, -1, 3'b000, 0);

    voice_en = 3'b111;
    gain_shift = 2'd0;
    pulse(3'b001, 10, 0, 0);
    pulse(3'b001, 20, 0, 0);
    chk("s037.ovr", int'(overrun), 1);
    pulse(3'b010, 0, 30, 0);
    pulse(3'b100, 0, 0, 40);
    wait_valid(n);
    chk("s037.lat", n, 2);
    chk("s037.out", int'($signed(sample_out)), 90);
    tick();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    mclip = 1'b0;
    chk("s037.clr", int'(overrun), 0);

    pulse(3'b001, 100, 0, 0);
    pulse(3'b010, 0, 200, 0);
    pulse(3'b100, 0, 0, 300);
    tick();
    chk("s022.sum", int'(sample_valid), 0);
    pulse(3'b001, 7, 0, 0);
    chk("s022.valid", int'(sample_valid), 1);
    chk("s022.out1", int'($signed(sample_out)), 600);
    pulse(3'b010, 0, 8, 0);
    pulse(3'b100, 0, 0, 9);
    wait_valid(n);
    chk("s022.lat", n, 2);
    chk("s022.out2", int'($signed(sample_out)), 24);
    tick();

    pulse(3'b001, 77, 0, 0);
    pulse(3'b010, 0, 88, 0);
    reset = 1'b0;
    #2;
    chk("s038.out", int'(sample_out), 0);
    chk("s038.ovr", int'(overrun), 0);
    tick();
    tick();
    reset = 1'b1;
    mhold = '{0, 0, 0};
    mclip = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (sample_valid !== 1'b0) seen = 1'b1;
    end
    chk("s038.novalid", int'(seen), 0);
    chk("s038.hold", int'(sample_out), 0);
    run_frame("s038.new", 5, 6, 0, 0, 1, -1, 3'b111, 0);

    for (int f = 0; f < 12; f++) begin
      ren = 3'($urandom_range(1, 7));
      rsh = int'($urandom_range(0, 3));
      rmax = 0;
      for (int k = 0; k < 3; k++) begin
        rv[k] = int'($urandom_range(0, 65535)) - 32768;
        ro[k] = ren[k] ? int'($urandom_range(0, 4)) : -1;
        if (ro[k] > rmax) rmax = ro[k];
      end
      for (int k = 0; k < 3; k++) begin
        if (!ren[k] && $urandom_range(0, 1) == 1)
          ro[k] = int'($urandom_range(0, rmax));
      end
      run_frame("rand", rv[0], rv[1], rv[2], ro[0], ro[1], ro[2],
                ren, rsh);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the cycle limit for collecting voices after the first capture of a frame.
REQ-002 SHALL have parameter NUM_VOICES, default 3, meaning the voice count, fixed at 3 in this revision.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port reset, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port sample_in_0/1/2, input, 16 each, signed note_player samples.
REQ-006 SHALL have port ready_in, input, 3, per-voice one-cycle new_sample_ready pulses.
REQ-007 SHALL have port voice_en, input, 3, per-voice enable; a disabled voice contributes 0 and is never waited on.
REQ-008 SHALL have port gain_shift, input, 2, arithmetic right shift applied to the sum (0..3).
REQ-009 SHALL have port sample_out, output, 16, signed mixed sample, held between frames.
REQ-010 SHALL have port sample_valid, output, 1, one-cycle pulse when sample_out updates.
REQ-011 SHALL have port overrun, output, 1, sticky; set when a voice re-pulses while already pending.
REQ-012 SHALL have port clip, output, 1, sticky; set when saturation occurred.
REQ-013 SHALL have port clear_flags, input, 1, synchronous clear of overrun and clip.

Function
REQ-014 SHALL capture sample_in_k into hold_k and set pending[k] on the rising edge where ready_in[k]=1.
REQ-015 SHALL implement states IDLE, COLLECT, SUM, OUT.
REQ-016 IDLE SHALL go to COLLECT on any enabled capture, and SHALL clear the timeout counter.
REQ-017 COLLECT SHALL go to SUM when (pending & voice_en) == voice_en, or when the timeout counter reaches TIMEOUT-1.
REQ-018 On timeout, missing voices SHALL contribute their stale hold_k value.
REQ-019 SUM SHALL compute an 18-bit signed sum of enabled hold_k, apply an arithmetic shift right by gain_shift, register the result to sample_out, and clear pending, then go to OUT.
REQ-020 OUT SHALL assert sample_valid for exactly one cycle, then go to IDLE, or directly to COLLECT if any pending bit is set.
REQ-021 Latency: sample_valid SHALL assert exactly 2 cycles after the edge capturing the last required voice.
REQ-022 A ready pulse arriving during SUM or OUT SHALL be captured and kept pending for the next frame; a clear in SUM SHALL NOT lose it.
REQ-023 A ready pulse on a voice already pending in COLLECT SHALL overwrite hold_k and set overrun.
REQ-024 If voice_en==0, any ready pulse SHALL produce a frame with sample_out=0.
REQ-025 If voice_en changes mid-COLLECT, the completion test SHALL use the current value.
REQ-026 If clear_flags coincides with a set condition, set SHALL win.

Reset
REQ-027 While reset=0: state=IDLE; hold_k, pending, counter, sample_out=0; sample_valid, overrun, clip=0.
REQ-028 Reset asserted mid-frame SHALL discard the frame with no sample_valid afterwards until new captures complete.

Configuration
REQ-029 With VOICE_MIXER_SAT_EN defined, the shifted sum SHALL saturate to [-32768, 32767] and set clip when limited.
REQ-030 Without VOICE_MIXER_SAT_EN, the output SHALL be the low 16 bits of the shifted sum (wrap), and clip SHALL be tied 0.

Structure
REQ-031 Package voice_mixer_pkg SHALL hold the state enum, SAMPLE_W=16, SUM_W=18, and NUM_VOICES_MAX=3.
REQ-032 Per-voice capture (hold register, pending bit, overrun detect) SHALL be sub-module mix_voice_slot, instantiated 3 times.

Verification
REQ-033 Scenario: voices 1000/2000/3000, all enabled, shift 0, ready pulses on cycles 10, 12, 15 -> sample_out=6000, sample_valid at cycle 17 only.
REQ-034 Scenario: 20000 x3, shift 0 -> 32767 and clip=1 with SAT_EN; -5536 and clip=0 without.
REQ-035 Scenario: TIMEOUT=8, voices 0/1 pulse (100, 200), hold_2=50 stale -> sample_out=350, 8 cycles after first capture +2.
REQ-036 Scenario: voice_en=3'b101, -4000 and 1000, shift 1 -> sample_out=-1500; voice 1 pulses are ignored for completion.
REQ-037 Scenario: voice 0 pulses twice in COLLECT (10 then 20) -> hold_0=20, overrun=1; clear_flags -> overrun=0.
REQ-038 Scenario: reset pulled low in COLLECT, then released -> all outputs 0 and no sample_valid until a full new frame.
